if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Clocking: one clock; reset is synchronous and active-high; ports are named clock and reset.
REQ-003 Port: clock  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: stall  input  1  downstream hazard stall; hold outputs.
REQ-006 Port: branch_taken  input  1  redirect/flush request from EX.
REQ-007 Port: branch_target  input  32  redirect address.
REQ-008 Port: imem_req  output  1  fetch request valid.
REQ-009 Port: imem_addr  output  32  fetch address; equals fetch_pc.
REQ-010 Port: imem_gnt  input  1  memory accepts request this cycle.
REQ-011 Port: imem_rvalid  input  1  read data valid; at least 1 cycle after grant.
REQ-012 Port: imem_rdata  input  32  instruction word.
REQ-013 Port: PC_out  output  32  registered address of presented instruction, to IF/ID stage.
REQ-014 Port: instr_out  output  32  registered instruction; 0 (NOP) when invalid.
REQ-015 Port: instr_valid  output  1  registered; instr_out is a real fetched instruction.

Function
REQ-016 State machine: IDLE (may request), WAIT (one request outstanding), DISCARD (outstanding response belongs to a squashed path).
REQ-017 Internal: fetch_pc (32), req_pc (32), one-entry hold buffer (buf_valid, buf_pc, buf_instr).
REQ-018 imem_req = (state==IDLE) & ~reset & ~branch_taken & ~buf_valid; combinational, no other terms.
REQ-019 Grant (imem_req & imem_gnt): req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 modulo 2^32 (FFFF_FFFC wraps to 0000_0000), state->WAIT.
REQ-020 At most one outstanding request; steady-state throughput one instruction per 2 cycles with single-cycle memory.
REQ-021 WAIT & imem_rvalid & ~branch_taken: state->IDLE; if stall=0 and buf_valid=0, outputs<={req_pc, imem_rdata, 1}; otherwise captured into buffer.
REQ-022 stall=1 & ~branch_taken: PC_out, instr_out, instr_valid hold.
REQ-023 stall=0 & ~branch_taken & buf_valid: outputs<=buffer contents, buf_valid<=0 (buffer drains before any new response).
REQ-024 stall=0 & ~branch_taken with no buffer or response data: instr_out<=0, instr_valid<=0, PC_out holds (bubble).
REQ-025 branch_taken=1 overrides stall: fetch_pc<={branch_target[31:2],2'b00}; instr_out<=0; instr_valid<=0; buf_valid<=0; no request.
REQ-026 Redirect in WAIT without imem_rvalid: state->DISCARD; with imem_rvalid same cycle: data dropped, state->IDLE.
REQ-027 Redirect in DISCARD: fetch_pc updated, state stays DISCARD.
REQ-028 DISCARD & imem_rvalid: data dropped, state->IDLE; outputs follow REQ-022/024.
REQ-029 imem_rvalid in IDLE ignored; imem_gnt ignored while imem_req=0.

Reset
REQ-030 reset=1 at clock edge: fetch_pc<=RESET_PC, state->IDLE, buf_valid<=0, PC_out<=0, instr_out<=0, instr_valid<=0; imem_req=0 during reset cycle.
REQ-031 Reset mid-request (WAIT/DISCARD): outstanding response abandoned; a later imem_rvalid arriving in IDLE ignored per REQ-029.
REQ-032 Reset has priority over branch_taken, stall and all handshakes.

Verification
REQ-033 Reset release, RESET_PC=0, gnt=1, rvalid 1 cycle later, rdata=0x2002_0005: imem_addr 0, then 4; PC_out=0, instr_out=0x2002_0005, instr_valid=1 two cycles after first request.
REQ-034 stall=1 held 4 cycles while response 0x1111_1111 for PC 8 returns: outputs hold previous instr; imem_req=0 after buffer fills; on stall release PC_out=8, instr_out=0x1111_1111 next edge.
REQ-035 branch_taken=1, target=0x0000_0043, during WAIT: next request address 0x0000_0040; squashed rvalid dropped; instr_valid=0 for the redirect cycle.
REQ-036 Redirect coincident with stall=1 and full buffer: buffer cleared, instr_out=0, instr_valid=0, fetch resumes at target.
REQ-037 Wrap: fetch_pc=0xFFFF_FFFC granted -> next imem_addr 0x0000_0000.
REQ-038 reset asserted in WAIT, late rvalid with rdata=0xDEAD_BEEF: instr_valid stays 0, imem_addr=RESET_PC after reset.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, a one-entry hold buffer
// to absorb a response that arrives while stalled, and squashing of in-flight fetches on redirect.
//
// state   | meaning
// IDLE    | no request outstanding; may issue a fetch
// WAIT    | one request granted, response pending
// DISCARD | response pending belongs to a squashed path; drop it
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC_out,
   output logic [31:0] instr_out,
   output logic        instr_valid
);

   typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc;
   logic [31:0] req_pc;
   logic        buf_valid;
   logic [31:0] buf_pc;
   logic [31:0] buf_instr;
   logic        grant;
   logic        resp;
   logic        unused_target_lsbs;

   assign imem_req  = (state_q == IDLE) & ~reset & ~branch_taken & ~buf_valid;
   assign imem_addr = fetch_pc;
   assign grant     = imem_req & imem_gnt;
   assign resp      = (state_q == WAIT) & imem_rvalid & ~branch_taken;

   // Redirect targets are word aligned; the low bits are intentionally ignored.
   assign unused_target_lsbs = ^branch_target[1:0];

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant) state_d = WAIT;
         end
         WAIT: begin
            if (imem_rvalid)       state_d = IDLE;
            else if (branch_taken) state_d = DISCARD;
         end
         DISCARD: begin
            if (imem_rvalid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         fetch_pc    <= RESET_PC;
         req_pc      <= RESET_PC;
         buf_valid   <= 1'b0;
         buf_pc      <= 32'h0;
         buf_instr   <= 32'h0;
         PC_out      <= 32'h0;
         instr_out   <= 32'h0;
         instr_valid <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (branch_taken) begin
            fetch_pc    <= {branch_target[31:2], 2'b00};
            instr_out   <= 32'h0;
            instr_valid <= 1'b0;
            buf_valid   <= 1'b0;
         end else if (stall) begin
            if (resp) begin
               buf_valid <= 1'b1;
               buf_pc    <= req_pc;
               buf_instr <= imem_rdata;
            end
         end else if (buf_valid) begin
            // Buffered instruction is older than any response arriving now.
            PC_out      <= buf_pc;
            instr_out   <= buf_instr;
            instr_valid <= 1'b1;
            buf_valid   <= resp;
            if (resp) begin
               buf_pc    <= req_pc;
               buf_instr <= imem_rdata;
            end
         end else if (resp) begin
            PC_out      <= req_pc;
            instr_out   <= imem_rdata;
            instr_valid <= 1'b1;
         end else begin
            instr_out   <= 32'h0;
            instr_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: single-cycle memory responder, directed redirect/stall/reset
// scenarios, and a scoreboard monitor that checks each freshly presented instruction.
module tb_if_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] PC_out;
   logic [31:0] instr_out;
   logic        instr_valid;

   logic        rsp_en;
   logic        rsp_rv;
   logic [31:0] rsp_data;
   logic        man_rv;
   logic [31:0] man_data;
   logic        reset_e = 1'b1;
   logic        stall_e = 1'b1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;
   exp_t exp_q[$];

   if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clock        (clock),
      .reset        (reset),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_gnt     (imem_gnt),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .PC_out       (PC_out),
      .instr_out    (instr_out),
      .instr_valid  (instr_valid)
   );

   always #5 clock = ~clock;

   assign imem_rvalid = rsp_rv | man_rv;
   assign imem_rdata  = man_rv ? man_data : rsp_data;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h2002_0005;
      if (a == 32'h8) return 32'h1111_1111;
      return {16'hC0DE, a[15:0]};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] instr);
      exp_t e;
      e.pc    = pc;
      e.instr = instr;
      exp_q.push_back(e);
   endtask

   // Memory: a request granted in one cycle returns data in the next.
   initial begin
      logic        g;
      logic [31:0] a;
      rsp_rv   = 1'b0;
      rsp_data = 32'h0;
      forever begin
         @(negedge clock);
         g = imem_req & imem_gnt & rsp_en;
         a = imem_addr;
         @(posedge clock);
         #1;
         rsp_rv   = g;
         rsp_data = mem_word(a);
      end
   end

   always @(posedge clock) begin
      reset_e <= reset;
      stall_e <= stall;
   end

   // An instruction is freshly presented when the last edge was unstalled and out of reset.
   always @(negedge clock) begin
      if (!reset_e && !stall_e && instr_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_instr: got pc %h instr %h expected none", PC_out, instr_out);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_pc", PC_out, e.pc);
            chk("sb_instr", instr_out, e.instr);
         end
      end
   end

   initial begin
      reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
      imem_gnt = 1'b1; rsp_en = 1'b1; man_rv = 1'b0; man_data = 32'h0;
      repeat (3) tick();
      chk("rst_req", {31'h0, imem_req}, 32'h0);
      chk("rst_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst_pc", PC_out, 32'h0);
      chk("rst_instr", instr_out, 32'h0);

      reset = 1'b0; #2;
      chk("first_req", {31'h0, imem_req}, 32'h1);
      chk("first_addr", imem_addr, 32'h0);
      push(32'h0, 32'h2002_0005);
      tick();
      chk("one_outstanding", {31'h0, imem_req}, 32'h0);
      tick();
      chk("pc0", PC_out, 32'h0);
      chk("instr0", instr_out, 32'h2002_0005);
      chk("second_addr", imem_addr, 32'h4);
      push(32'h4, 32'hC0DE_0004);
      tick(); tick();
      chk("third_addr", imem_addr, 32'h8);
      push(32'h8, 32'h1111_1111);

      // Stall while the response for PC 8 returns.
      tick(); stall = 1'b1;
      tick();
      chk("stall_req", {31'h0, imem_req}, 32'h0);
      chk("stall_pc_hold", PC_out, 32'h4);
      chk("stall_valid_hold", {31'h0, instr_valid}, 32'h0);
      repeat (3) tick();
      chk("stall_req_late", {31'h0, imem_req}, 32'h0);
      chk("stall_pc_late", PC_out, 32'h4);
      stall = 1'b0;
      tick();
      chk("drain_pc", PC_out, 32'h8);
      chk("drain_instr", instr_out, 32'h1111_1111);
      chk("after_drain_addr", imem_addr, 32'hC);
      chk("after_drain_req", {31'h0, imem_req}, 32'h1);

      // Redirect while waiting; the late response must be dropped.
      rsp_en = 1'b0;
      tick(); branch_taken = 1'b1; branch_target = 32'h0000_0043;
      tick(); branch_taken = 1'b0; man_rv = 1'b1; man_data = 32'hDEAD_0012; #2;
      chk("redir_valid", {31'h0, instr_valid}, 32'h0);
      chk("discard_req", {31'h0, imem_req}, 32'h0);
      tick(); man_rv = 1'b0; rsp_en = 1'b1; #2;
      chk("redir_addr", imem_addr, 32'h40);
      chk("redir_req", {31'h0, imem_req}, 32'h1);
      chk("squash_valid", {31'h0, instr_valid}, 32'h0);
      push(32'h40, 32'hC0DE_0040);
      tick(); tick();
      chk("redir_fetch_pc", PC_out, 32'h40);

      // Redirect with stall and a full buffer.
      tick(); stall = 1'b1;
      tick();
      chk("buf_full_req", {31'h0, imem_req}, 32'h0);
      branch_taken = 1'b1; branch_target = 32'h0000_0100;
      tick(); branch_taken = 1'b0; stall = 1'b0; #2;
      chk("flush_valid", {31'h0, instr_valid}, 32'h0);
      chk("flush_instr", instr_out, 32'h0);
      chk("flush_addr", imem_addr, 32'h100);
      chk("flush_req", {31'h0, imem_req}, 32'h1);
      push(32'h100, 32'hC0DE_0100);
      tick(); tick();

      // Wrap at the top of the address space.
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; #2;
      chk("branch_blocks_req", {31'h0, imem_req}, 32'h0);
      tick(); branch_taken = 1'b0; #2;
      chk("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
      push(32'hFFFF_FFFC, 32'hC0DE_FFFC);
      tick(); tick();
      chk("wrap_addr", imem_addr, 32'h0);
      chk("wrap_pc", PC_out, 32'hFFFF_FFFC);

      // Redirect coincident with the response: data dropped.
      tick(); branch_taken = 1'b1; branch_target = 32'h0000_0200;
      tick(); branch_taken = 1'b0; rsp_en = 1'b0; #2;
      chk("drop_valid", {31'h0, instr_valid}, 32'h0);
      chk("drop_addr", imem_addr, 32'h200);

      // Reset while waiting, then a late response arrives in IDLE.
      tick(); reset = 1'b1; #2;
      chk("rst_cycle_req", {31'h0, imem_req}, 32'h0);
      tick(); reset = 1'b0; imem_gnt = 1'b0; man_rv = 1'b1; man_data = 32'hDEAD_BEEF; #2;
      chk("post_rst_addr", imem_addr, 32'h0);
      chk("post_rst_req", {31'h0, imem_req}, 32'h1);
      chk("post_rst_valid", {31'h0, instr_valid}, 32'h0);
      tick(); man_rv = 1'b0; #2;
      chk("late_rvalid_valid", {31'h0, instr_valid}, 32'h0);
      chk("late_rvalid_instr", instr_out, 32'h0);
      chk("late_rvalid_addr", imem_addr, 32'h0);
      imem_gnt = 1'b1; rsp_en = 1'b1;
      push(32'h0, 32'h2002_0005);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      tick();
      chk("sb_drained", exp_q.size(), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
